// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: definitions shared by the instruction-fetch stage.
//   IF_NOP_INST     : canonical NOP (addi x0,x0,0), driven for empty and faulted slots
//   IF_CAUSE_MISALN : trap cause code for a misaligned instruction fetch
//   if_slot_t       : one fetch-queue slot
//   IF_LOG(args)    : event logging, expands to nothing unless IS_SIMULATION is defined
`ifndef INST_FETCH_PKG_SV
`define INST_FETCH_PKG_SV

`ifdef IS_SIMULATION
  `define IF_LOG(args) $display args
`else
  `define IF_LOG(args)
`endif

package inst_fetch_pkg;

  localparam logic [31:0] IF_NOP_INST     = 32'h0000_0013;
  localparam logic [3:0]  IF_CAUSE_MISALN = 4'd0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
    logic        filled;
  } if_slot_t;

  function automatic logic if_pc_aligned(input logic [31:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

endpackage

`endif

// File: rtl/inst_fetch_queue.sv
// fetch_queue: in-order slot buffer for the fetch stage.
//   clk, rst            : clock, async active-high reset
//   i_flush             : drop every slot, pointers back to 0
//   i_alloc/_pc/_fault  : allocate a slot at the tail (faulted slots arrive pre-filled)
//   i_fill/_data        : memory response for the oldest allocated-but-unfilled slot
//   i_pop               : retire the head slot
//   o_head_*            : head slot view (zeros/NOP when not presentable)
//   o_occ, o_unfilled   : allocated slots, and allocated slots still awaiting data
module fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = IF_NOP_INST
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_alloc,
  input  logic [31:0]                i_alloc_pc,
  input  logic                       i_alloc_fault,
  input  logic                       i_fill,
  input  logic [31:0]                i_fill_data,
  input  logic                       i_pop,
  output logic                       o_head_valid,
  output logic [31:0]                o_head_pc,
  output logic [31:0]                o_head_inst,
  output logic                       o_head_fault,
  output logic [$clog2(DEPTH+1)-1:0] o_occ,
  output logic [$clog2(DEPTH+1)-1:0] o_unfilled
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if_slot_t         r_slot [DEPTH];
  logic [DEPTH-1:0] r_used;
  logic [PW-1:0]    r_alloc_ptr, r_fill_ptr, r_head_ptr;
  logic [CW-1:0]    r_occ;

  logic [PW-1:0]    w_fill_idx, w_scan;
  logic             w_found;
  logic [CW-1:0]    w_unfilled;
  if_slot_t         w_head;

  // Responses belong to the oldest allocated slot still waiting for data.
  // Scan forward from fill_ptr so faulted (pre-filled) and free slots are skipped.
  always_comb begin
    w_fill_idx = r_fill_ptr;
    w_found    = 1'b0;
    w_scan     = r_fill_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      w_scan = r_fill_ptr + PW'(i);
      if (!w_found && r_used[w_scan] && !r_slot[w_scan].filled) begin
        w_fill_idx = w_scan;
        w_found    = 1'b1;
      end
    end
  end

  always_comb begin
    w_unfilled = '0;
    for (int i = 0; i < DEPTH; i++)
      if (r_used[i] && !r_slot[i].filled) w_unfilled = w_unfilled + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_used      <= '0;
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_occ       <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_slot[i] <= '{pc: 32'h0, inst: NOP_INST, fault: 1'b0, filled: 1'b0};
    end else if (i_flush) begin
      r_used      <= '0;
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_occ       <= '0;
    end else begin
      if (i_alloc) begin
        r_slot[r_alloc_ptr] <= '{pc: i_alloc_pc, inst: NOP_INST,
                                 fault: i_alloc_fault, filled: i_alloc_fault};
        r_used[r_alloc_ptr] <= 1'b1;
        r_alloc_ptr         <= r_alloc_ptr + PW'(1);
      end
      if (i_fill) begin
        r_slot[w_fill_idx].inst   <= i_fill_data;
        r_slot[w_fill_idx].filled <= 1'b1;
        r_fill_ptr                <= w_fill_idx + PW'(1);
      end
      if (i_pop) begin
        r_used[r_head_ptr] <= 1'b0;
        r_head_ptr         <= r_head_ptr + PW'(1);
      end
      r_occ <= r_occ + CW'(i_alloc) - CW'(i_pop);
    end
  end

  assign w_head       = r_slot[r_head_ptr];
  assign o_head_valid = r_used[r_head_ptr] & w_head.filled;
  assign o_head_pc    = o_head_valid ? w_head.pc    : 32'h0;
  assign o_head_inst  = o_head_valid ? w_head.inst  : NOP_INST;
  assign o_head_fault = o_head_valid ? w_head.fault : 1'b0;
  assign o_occ        = r_occ;
  assign o_unfilled   = w_unfilled;

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: fetch stage between the PC register and decode.
//   clk, rst                         : clock, async active-high reset
//   fetch_pc/valid -> fetch_ready    : PC handshake; PC advances only on fetch_ready
//   flush                            : redirect, kills queued and in-flight fetches
//   imem_req/addr, imem_gnt          : memory request channel
//   imem_rvalid/rdata                : in-order memory responses
//   if_valid/ready, if_pc/inst/fault : head entry towards decode
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = IF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_fault
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] w_occ, w_unfilled;
  logic          w_credit, w_aligned, w_go;
  logic          w_alloc, w_fill, w_drop_rsp, w_pop;

  // Credit counts responses still owed to us for killed fetches, so a refill
  // after flush can never overrun the slots. Registered values only: a pop or
  // drop this cycle frees credit next cycle.
  assign w_credit  = ({1'b0, w_occ} + {1'b0, r_drop_cnt}) < DEPTH_W;
  assign w_aligned = if_pc_aligned(fetch_pc);
  assign w_go      = fetch_valid & w_credit & ~flush & ~rst;

  assign imem_req    = w_go & w_aligned;
  assign imem_addr   = fetch_pc;
  // Misaligned PCs never touch memory; they take a slot as a pre-filled fault.
  assign fetch_ready = w_aligned ? (imem_req & imem_gnt) : w_go;

  assign w_alloc    = fetch_ready;
  assign w_drop_rsp = imem_rvalid & (r_drop_cnt != '0);
  assign w_fill     = imem_rvalid & (r_drop_cnt == '0) & ~flush;
  assign w_pop      = if_valid & if_ready & ~flush;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .NOP_INST (NOP_INST)
  ) u_queue (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (flush),
    .i_alloc       (w_alloc),
    .i_alloc_pc    (fetch_pc),
    .i_alloc_fault (~w_aligned),
    .i_fill        (w_fill),
    .i_fill_data   (imem_rdata),
    .i_pop         (w_pop),
    .o_head_valid  (if_valid),
    .o_head_pc     (if_pc),
    .o_head_inst   (if_inst),
    .o_head_fault  (if_fault),
    .o_occ         (w_occ),
    .o_unfilled    (w_unfilled)
  );

  // On flush every unfilled slot turns into a response to discard; a response
  // landing in the flush cycle itself is already one of them and is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_drop_cnt <= '0;
    else if (flush)
      r_drop_cnt <= r_drop_cnt + w_unfilled - CW'(imem_rvalid);
    else if (w_drop_rsp)
      r_drop_cnt <= r_drop_cnt - CW'(1);
  end

`ifndef SYNTHESIS
  // A response is only legal while something is outstanding or owed.
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (r_drop_cnt != '0 || w_unfilled != '0));
`endif

`ifdef IS_SIMULATION
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (flush)      `IF_LOG(("[inst_fetch] flush drop=%0d unfilled=%0d", r_drop_cnt, w_unfilled));
      if (w_alloc)    `IF_LOG(("[inst_fetch] alloc pc=%h fault=%0d cause=%0d", fetch_pc, ~w_aligned, IF_CAUSE_MISALN));
      if (w_fill)     `IF_LOG(("[inst_fetch] fill  inst=%h", imem_rdata));
      if (w_drop_rsp) `IF_LOG(("[inst_fetch] drop  inst=%h", imem_rdata));
      if (w_pop)      `IF_LOG(("[inst_fetch] pop   pc=%h inst=%h", if_pc, if_inst));
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        fetch_valid, fetch_ready, flush;
  logic        imem_req, imem_gnt;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic        if_valid, if_ready, if_fault;
  logic [31:0] if_pc, if_inst;

  int n_chk = 0, n_err = 0, cyc = 0, lat = 1;

  typedef struct { logic [31:0] pc; logic [31:0] inst; logic fault; logic filled; } ent_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic fault; int cyc; } cap_t;

  ent_t mq[$];       // model: entries in program order
  int   m_drops = 0; // model: responses still owed for killed fetches
  rsp_t pend[$];     // memory: granted requests awaiting response
  cap_t cap[$];      // entries actually handed to decode

  inst_fetch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .if_fault(if_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hDEAD_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_cap(input int i, input logic [31:0] pc, input logic [31:0] inst, input logic f);
    if (i >= cap.size()) begin
      n_chk++; n_err++;
      $display("FAIL cap%0d_present: got %0d entries, required more than %0d", i, cap.size(), i);
    end else begin
      chk($sformatf("cap%0d_pc", i), cap[i].pc, pc);
      chk($sformatf("cap%0d_inst", i), cap[i].inst, inst);
      chk($sformatf("cap%0d_fault", i), 32'(cap[i].fault), 32'(f));
    end
  endtask

  // Memory responder: one response per cycle, in grant order, after `lat` cycles.
  always @(posedge clk) begin
    #1;
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend[0].data;
      pend.delete(0);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  end

  // Reference model and per-cycle compare.
  always @(negedge clk) begin : model
    logic credit, aligned, e_req, e_fr, hv;
    int nu;
    if (rst) begin
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_inst", if_inst, NOP);
      chk("rst_if_fault", 32'(if_fault), 32'd0);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_fetch_ready", 32'(fetch_ready), 32'd0);
      mq.delete(); m_drops = 0; pend.delete();
    end else begin
      credit  = (mq.size() + m_drops) < DEPTH;
      aligned = (fetch_pc[1:0] == 2'b00);
      e_req   = fetch_valid && credit && !flush && aligned;
      e_fr    = aligned ? (e_req && imem_gnt) : (fetch_valid && credit && !flush);
      hv      = (mq.size() > 0) && mq[0].filled;
      chk("imem_req", 32'(imem_req), 32'(e_req));
      chk("fetch_ready", 32'(fetch_ready), 32'(e_fr));
      if (e_req) chk("imem_addr", imem_addr, fetch_pc);
      chk("if_valid", 32'(if_valid), 32'(hv));
      chk("if_pc", if_pc, hv ? mq[0].pc : 32'h0);
      chk("if_inst", if_inst, hv ? mq[0].inst : NOP);
      chk("if_fault", 32'(if_fault), hv ? 32'(mq[0].fault) : 32'd0);
      if (imem_req && imem_gnt) pend.push_back('{due: cyc + lat, data: mem_word(imem_addr)});
      if (if_valid && if_ready && !flush)
        cap.push_back('{pc: if_pc, inst: if_inst, fault: if_fault, cyc: cyc});
      if (flush) begin
        nu = 0;
        foreach (mq[i]) if (!mq[i].filled) nu++;
        m_drops = m_drops + nu - (imem_rvalid ? 1 : 0);
        mq.delete();
      end else begin
        if (imem_rvalid) begin
          if (m_drops > 0) m_drops--;
          else begin
            for (int i = 0; i < mq.size(); i++)
              if (!mq[i].filled) begin
                mq[i].inst = imem_rdata; mq[i].filled = 1'b1; break;
              end
          end
        end
        if (hv && if_ready) mq.delete(0);
        if (e_fr) mq.push_back('{pc: fetch_pc, inst: NOP, fault: !aligned, filled: !aligned});
      end
    end
  end

  task automatic wait_accept(output int acc);
    acc = -1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (fetch_ready) begin acc = cyc; break; end
    end
    n_chk++;
    if (acc < 0) begin
      n_err++;
      $display("FAIL fetch_accept: pc %h not accepted within 60 cycles", fetch_pc);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_fetch(input logic [31:0] pc, output int acc);
    fetch_pc = pc; fetch_valid = 1'b1;
    wait_accept(acc);
  endtask

  task automatic drain();
    bit done = 0;
    if_ready = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(posedge clk); #1;
      done = (mq.size() == 0 && m_drops == 0 && pend.size() == 0);
    end
    n_chk++;
    if (!done) begin
      n_err++;
      $display("FAIL drain: queue not empty after 200 cycles, got %0d entries, required 0", mq.size());
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a0, a1, a2, p;
    rst = 1'b1; fetch_valid = 1'b1; fetch_pc = 32'h0; flush = 1'b0;
    if_ready = 1'b0; imem_gnt = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; fetch_valid = 1'b0;

    // Back-to-back fetches, 1-cycle memory.
    lat = 1; if_ready = 1'b1; cap.delete();
    do_fetch(32'h0, a0); do_fetch(32'h4, a1); do_fetch(32'h8, a2);
    fetch_valid = 1'b0; drain();
    chk("b2b_count", 32'(cap.size()), 32'd3);
    chk_cap(0, 32'h0, 32'hDEAD_0000, 1'b0);
    chk_cap(1, 32'h4, 32'hDEAD_0004, 1'b0);
    chk_cap(2, 32'h8, 32'hDEAD_0008, 1'b0);

    // Backpressure: two slots fill, third waits for the first pop.
    if_ready = 1'b0; cap.delete();
    do_fetch(32'h20, a0); do_fetch(32'h24, a1);
    chk("bp_second_next_cycle", 32'(a1), 32'(a0 + 1));
    fetch_pc = 32'h28; fetch_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1; chk("bp_stalled", 32'(fetch_ready), 32'd0);
    if_ready = 1'b1; p = cyc;
    @(posedge clk); #1; if_ready = 1'b0;
    wait_accept(a2);
    chk("bp_third_after_pop", 32'(a2), 32'(p + 1));
    fetch_valid = 1'b0; drain();
    chk_cap(0, 32'h20, 32'hDEAD_0020, 1'b0);
    chk_cap(2, 32'h28, 32'hDEAD_0028, 1'b0);

    // Flush with two fetches in flight, then redirect.
    cap.delete(); lat = 6; if_ready = 1'b1;
    do_fetch(32'h10, a0); do_fetch(32'h14, a1);
    fetch_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    chk("flush_drop_cnt_2", 32'(dut.r_drop_cnt), 32'd2);
    @(posedge clk); #1;
    lat = 1;
    do_fetch(32'h1C09_0000, a2);
    fetch_valid = 1'b0; drain();
    chk("flush_drop_cnt_0", 32'(dut.r_drop_cnt), 32'd0);
    chk("flush_count", 32'(cap.size()), 32'd1);
    chk_cap(0, 32'h1C09_0000, 32'hC2A4_0000, 1'b0);

    // Flush in the same cycle as the first response.
    cap.delete(); lat = 3;
    do_fetch(32'h30, a0); do_fetch(32'h34, a1);
    fetch_valid = 1'b0;
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    chk("flush_rv_drop_cnt", 32'(dut.r_drop_cnt), 32'd1);
    @(posedge clk); #1;
    drain();
    chk("flush_rv_no_output", 32'(cap.size()), 32'd0);

    // Misaligned fetch behind an outstanding one, then on its own.
    cap.delete(); lat = 4;
    do_fetch(32'h40, a0); do_fetch(32'h6, a1);
    fetch_valid = 1'b0; drain();
    do_fetch(32'h2, a2);
    fetch_valid = 1'b0; drain();
    chk("misaln_count", 32'(cap.size()), 32'd3);
    chk_cap(0, 32'h40, 32'hDEAD_0040, 1'b0);
    chk_cap(1, 32'h6, 32'h0000_0013, 1'b1);
    chk_cap(2, 32'h2, 32'h0000_0013, 1'b1);

    // Async reset with an entry waiting at the head.
    cap.delete(); lat = 1; if_ready = 1'b0;
    do_fetch(32'h50, a0);
    fetch_valid = 1'b0;
    p = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (if_valid) begin p = 1; break; end
    end
    chk("rst_pre_valid", 32'(p), 32'd1);
    #2; rst = 1'b1;
    #1;
    chk("async_rst_if_valid", 32'(if_valid), 32'd0);
    chk("async_rst_if_inst", if_inst, 32'h0000_0013);
    chk("async_rst_if_pc", if_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1; chk("post_rst_empty", 32'(if_valid), 32'd0);
    if_ready = 1'b1;
    do_fetch(32'h60, a0);
    fetch_valid = 1'b0; drain();
    chk("post_rst_count", 32'(cap.size()), 32'd1);
    chk_cap(0, 32'h60, 32'hDEAD_0060, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current fetch PC and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers in-order responses in a DEPTH-entry queue and presents {pc, inst, fault} to decode with a valid/ready handshake.
- Branch/interrupt redirect flushes the queue and silently drops in-flight responses.

Parameters:
- DEPTH, 2, total entries: buffered plus outstanding requests (power of two, ≥2).
- NOP_INST, 32'h0000_0013, instruction value driven for empty/faulted slots (addi x0,x0,0).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- fetch_pc  in  32  PC to fetch (from PC register)
- fetch_valid  in  1  fetch_pc is a valid request
- fetch_ready  out  1  fetch_pc accepted this cycle; PC advances only when high
- flush  in  1  redirect (branch taken / interrupt); kills all queued and in-flight fetches
- imem_req  out  1  memory request
- imem_addr  out  32  word address; equals fetch_pc
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid; responses return in grant order, ≥1 cycle after grant
- imem_rdata  in  32  response instruction
- if_valid  out  1  head entry ready for decode
- if_ready  in  1  decode accepts head
- if_pc  out  32  PC of head entry
- if_inst  out  32  instruction of head entry
- if_fault  out  1  head entry is a misaligned-fetch fault

Behaviour:
- Queue: DEPTH slots {pc, inst, fault, filled}; alloc_ptr, fill_ptr, head_ptr, and occupancy count (0..DEPTH). drop_cnt counts in-flight responses to discard (0..DEPTH).
- Credit: credit = (occupancy + drop_cnt < DEPTH), using registered values. A same-cycle pop or drop does not create credit until the next cycle.
- Aligned fetch (fetch_pc[1:0]==0):
  - imem_req = fetch_valid & credit & ~flush.
  - fetch_ready = imem_req & imem_gnt.
  - On grant, allocate the slot at alloc_ptr with pc, fault=0, filled=0.
- Misaligned fetch:
  - imem_req=0; fetch_ready = fetch_valid & credit & ~flush.
  - Allocate a slot with pc, inst=NOP_INST, fault=1, filled=1; no memory traffic.
- Response, imem_rvalid with drop_cnt==0 and no flush:
  - Write imem_rdata into slot fill_ptr and set filled=1.
  - fill_ptr advances, skipping slots already filled (faulted).
- Response with drop_cnt>0: discard it and decrement drop_cnt.
- Output:
  - if_valid = head slot allocated & filled.
  - if_pc/if_inst/if_fault come from the head slot.
  - When if_valid=0: if_pc=0, if_inst=NOP_INST, if_fault=0.
  - Pop on if_valid & if_ready.
- Ordering: strictly in-order. A faulted entry behind an outstanding fetch is not presented before it.
- Flush (highest priority):
  - All slots are invalidated next cycle; pointers and occupancy return to 0.
  - drop_cnt <= drop_cnt + unfilled_outstanding − (imem_rvalid ? 1 : 0). An rvalid in the flush cycle is discarded and counted.
  - No allocation and no pop in the flush cycle (fetch_ready=0, imem_req=0).
  - The cycle after flush, fetch may issue if credit allows.
- Latency: grant in cycle N, rvalid in cycle N+k, if_valid in cycle N+k+1 (registered fill).
- Simultaneous alloc + fill + pop in one cycle: all legal and applied together; occupancy net = +alloc −pop.
- Reset (async): queue empty, all pointers, occupancy and drop_cnt = 0.
  - Outputs: if_valid=0, if_pc=0, if_inst=NOP_INST, if_fault=0.
  - imem_req and fetch_ready are forced 0 while rst is high.
  - Any response arriving after reset deassert with drop_cnt==0 is a protocol violation; assert in simulation.
- Under IS_SIMULATION, log each allocate/fill/pop/flush to the testbench output file.

Decomposition:
- Shared include (InstSpec): NOP_INST encoding, fault cause code for misaligned fetch, and the simulation logging macro.
- One natural sub-module: fetch_queue, holding the slot array, pointers, fill-skip logic and occupancy.
- inst_fetch keeps the handshake, credit and drop logic.

Test Plan:
- Back-to-back, gnt=1 always, rvalid 1 cycle later, if_ready=1.
  - Stimulus: fetch_pc 0x0, 0x4, 0x8.
  - Required: if_pc 0x0/0x4/0x8 on consecutive cycles; if_inst = memory words.
- Backpressure.
  - Stimulus: if_ready=0, DEPTH=2, three fetches.
  - Required: fetch_ready drops after 2 allocations; third accepted only the cycle after the first pop.
- Flush with 2 in flight.
  - Stimulus: grants at 0x10 and 0x14, flush before any rvalid, then fetch 0x1C09_0000.
  - Required: both late responses dropped (drop_cnt 2→0); first if_pc = 0x1C09_0000.
- Flush coincident with rvalid.
  - Required: that response is discarded; drop_cnt = outstanding−1; no if_valid for the killed PC.
- Misaligned fetch.
  - Stimulus: fetch_pc 0x0000_0006.
  - Required: no imem_req; if_valid with if_fault=1, if_inst=0x0000_0013, if_pc=0x6, after any older outstanding entry.
- Async reset mid-operation.
  - Stimulus: rst pulse with an entry queued.
  - Required: if_valid=0, if_inst=0x0000_0013 immediately (no clock edge); queue empty after release.
